ina219_poller: RTL and testbench

Autonomous transaction sequencer that sits in front of `i2c_master` and owns its command interface. After enable it configures an INA219 by writing the configuration and calibration registers. It then polls shunt voltage, bus voltage, power and current at a fixed period, presenting each completed sample as one coherent register set with a one-cycle valid strobe. It replaces hand-driven start/eot sequencing by software or testbench tasks.

---
 rtl/ina219_poller.sv | 222 ++++++++++++++++++++++
 tb/tb_ina219_poller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ina219_poller.sv
// INA219 poller: drives the i2c_master command interface to configure the sensor, then samples
// shunt voltage, bus voltage, power and current periodically and publishes them as one coherent set.
module ina219_poller #(
  parameter logic [6:0]  SLV_ADDR    = 7'h40,
  parameter int unsigned POLL_PERIOD = 5000,
  parameter int unsigned START_LEN   = 2,
  parameter int unsigned GAP         = 10,
  parameter int unsigned TIMEOUT     = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        reconfig,
  input  logic [15:0] cfg_word,
  input  logic [15:0] cal_word,
  input  logic        err_clr,
  output logic        m_start,
  output logic        m_rd_wr,
  output logic        m_data_valid,
  output logic [6:0]  m_slv_addr,
  output logic [7:0]  m_pointer_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_eot,
  output logic [15:0] shunt_v,
  output logic [15:0] bus_v,
  output logic [15:0] power,
  output logic [15:0] current,
  output logic        sample_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_CAL, S_PTR, S_GAPW, S_RD, S_STORE, S_PERIOD
  } state_t;

  localparam logic [31:0] START_LAST  = 32'(START_LEN) - 32'd1;
  localparam logic [31:0] GAP_LAST    = 32'(GAP) - 32'd1;
  localparam logic [31:0] PERIOD_LAST = 32'(POLL_PERIOD) - 32'd1;
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT) - 32'd1;

  state_t      state_reg, state_next;
  logic [1:0]  idx_reg, idx_next;
  logic [31:0] cnt_reg;
  logic        wait_reg, eot_q_reg, pend_reg;
  logic [15:0] shadow_reg [4];

  logic        m_start_reg, m_rd_wr_reg, m_data_valid_reg;
  logic [6:0]  m_slv_addr_reg;
  logic [7:0]  m_pointer_addr_reg;
  logic [15:0] m_wdata_reg;
  logic [15:0] shunt_v_reg, bus_v_reg, power_reg, current_reg;
  logic        sample_valid_reg, busy_reg, err_reg;

  logic in_txn, eot_rise, txn_done, txn_tmo, cnt_zero, launch, publish;

  // Only a rising eot seen after m_start has dropped completes a transaction.
  assign in_txn   = (state_reg == S_CFG) || (state_reg == S_CAL) ||
                    (state_reg == S_PTR) || (state_reg == S_RD);
  assign eot_rise = m_eot && !eot_q_reg;
  assign txn_done = in_txn && wait_reg && eot_rise;
  assign txn_tmo  = in_txn && wait_reg && !eot_rise && (cnt_reg == TMO_LAST);
  assign cnt_zero = (cnt_reg == 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    publish    = 1'b0;
    unique case (state_reg)
      S_IDLE:  if (enable) state_next = S_CFG;
      S_CFG:   if (txn_done) state_next = enable ? S_CAL : S_IDLE;
      S_CAL: begin
        if (txn_done) begin
          state_next = enable ? S_PTR : S_IDLE;
          idx_next   = 2'd0;
        end
      end
      S_PTR:   if (txn_done) state_next = enable ? S_GAPW : S_IDLE;
      S_GAPW: begin
        if (!enable)       state_next = S_IDLE;
        else if (cnt_zero) state_next = S_RD;
      end
      S_RD:    if (txn_done) state_next = enable ? S_STORE : S_IDLE;
      S_STORE: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (idx_reg != 2'd3) begin
          state_next = S_PTR;
          idx_next   = idx_reg + 2'd1;
        end else begin
          state_next = S_PERIOD;
          publish    = 1'b1;
        end
      end
      S_PERIOD: begin
        if (!enable) begin
          state_next = S_IDLE;
        end else if (cnt_zero) begin
          state_next = pend_reg ? S_CFG : S_PTR;
          idx_next   = 2'd0;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (txn_tmo) state_next = S_PERIOD;
    launch = (state_next != state_reg) &&
             (state_next inside {S_CFG, S_CAL, S_PTR, S_RD});
  end

  // Command fields, transaction timing and the shared cycle counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_reg            <= 2'd0;
      cnt_reg            <= 32'd0;
      wait_reg           <= 1'b0;
      eot_q_reg          <= 1'b0;
      m_start_reg        <= 1'b0;
      m_rd_wr_reg        <= 1'b0;
      m_data_valid_reg   <= 1'b0;
      m_slv_addr_reg     <= 7'd0;
      m_pointer_addr_reg <= 8'd0;
      m_wdata_reg        <= 16'd0;
      busy_reg           <= 1'b0;
    end else begin
      eot_q_reg <= m_eot;
      idx_reg   <= idx_next;
      if (state_next != state_reg) begin
        unique case (state_next)
          S_GAPW:   cnt_reg <= GAP_LAST;
          S_PERIOD: cnt_reg <= PERIOD_LAST;
          default:  cnt_reg <= START_LAST;
        endcase
      end else if (in_txn && !wait_reg) begin
        if (cnt_zero) begin
          m_start_reg <= 1'b0;
          wait_reg    <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg - 32'd1;
        end
      end else if (in_txn) begin
        cnt_reg <= cnt_reg + 32'd1;
      end else if (!cnt_zero) begin
        cnt_reg <= cnt_reg - 32'd1;
      end

      if (launch) begin
        m_start_reg    <= 1'b1;
        wait_reg       <= 1'b0;
        busy_reg       <= 1'b1;
        m_slv_addr_reg <= SLV_ADDR;
        unique case (state_next)
          S_CFG: begin
            m_rd_wr_reg <= 1'b0; m_data_valid_reg <= 1'b1;
            m_pointer_addr_reg <= 8'h00; m_wdata_reg <= cfg_word;
          end
          S_CAL: begin
            m_rd_wr_reg <= 1'b0; m_data_valid_reg <= 1'b1;
            m_pointer_addr_reg <= 8'h05; m_wdata_reg <= cal_word;
          end
          S_PTR: begin
            m_rd_wr_reg <= 1'b0; m_data_valid_reg <= 1'b0;
            m_pointer_addr_reg <= {6'd0, idx_next} + 8'd1; m_wdata_reg <= 16'd0;
          end
          default: begin
            m_rd_wr_reg <= 1'b1; m_data_valid_reg <= 1'b0;
            m_wdata_reg <= 16'd0;
          end
        endcase
      end else if (txn_done || txn_tmo) begin
        busy_reg <= 1'b0;
      end
    end
  end

  // Shadows, published sample set, reconfig request and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) shadow_reg[i] <= 16'd0;
      shunt_v_reg      <= 16'd0;
      bus_v_reg        <= 16'd0;
      power_reg        <= 16'd0;
      current_reg      <= 16'd0;
      sample_valid_reg <= 1'b0;
      pend_reg         <= 1'b0;
      err_reg          <= 1'b0;
    end else begin
      if (state_reg == S_STORE) shadow_reg[idx_reg] <= m_rdata;
      sample_valid_reg <= publish;
      if (publish) begin
        shunt_v_reg <= shadow_reg[0];
        bus_v_reg   <= shadow_reg[1];
        power_reg   <= shadow_reg[2];
        current_reg <= m_rdata;
      end
      if (state_next == S_CFG && state_reg != S_CFG) pend_reg <= 1'b0;
      else if (reconfig || txn_tmo)                  pend_reg <= 1'b1;
      if (txn_tmo)      err_reg <= 1'b1;
      else if (err_clr) err_reg <= 1'b0;
    end
  end

  assign m_start        = m_start_reg;
  assign m_rd_wr        = m_rd_wr_reg;
  assign m_data_valid   = m_data_valid_reg;
  assign m_slv_addr     = m_slv_addr_reg;
  assign m_pointer_addr = m_pointer_addr_reg;
  assign m_wdata        = m_wdata_reg;
  assign shunt_v        = shunt_v_reg;
  assign bus_v          = bus_v_reg;
  assign power          = power_reg;
  assign current        = current_reg;
  assign sample_valid   = sample_valid_reg;
  assign busy           = busy_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_ina219_poller.sv
// Bench for ina219_poller: an i2c_master/INA219 behavioural model answers transactions while a
// scoreboard checks every issued transaction and every published sample against queued expectations.
module tb_ina219_poller;

  localparam int POLL = 200;
  localparam int GAPC = 10;
  localparam int TMO  = 100;
  localparam int SAMPLE_SPACING = 292;  // 200 period + 4 x (6 ptr + 10 gap + 6 rd + 1 store)

  typedef struct packed {
    logic        rd;
    logic        dv;
    logic [7:0]  ptr;
    logic [15:0] data;
  } txn_t;

  typedef struct packed {
    logic [15:0] s;
    logic [15:0] b;
    logic [15:0] p;
    logic [15:0] c;
  } smp_t;

  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, reconfig = 1'b0, err_clr = 1'b0;
  logic [15:0] cfg_word = 16'h399F, cal_word = 16'h1000;
  logic        m_start, m_rd_wr, m_data_valid, m_eot = 1'b0;
  logic [6:0]  m_slv_addr;
  logic [7:0]  m_pointer_addr;
  logic [15:0] m_wdata, m_rdata = 16'd0;
  logic [15:0] shunt_v, bus_v, power, current;
  logic        sample_valid, busy, err;

  ina219_poller #(
    .SLV_ADDR(7'h40), .POLL_PERIOD(POLL), .START_LEN(2), .GAP(GAPC), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .reconfig(reconfig),
    .cfg_word(cfg_word), .cal_word(cal_word), .err_clr(err_clr),
    .m_start(m_start), .m_rd_wr(m_rd_wr), .m_data_valid(m_data_valid),
    .m_slv_addr(m_slv_addr), .m_pointer_addr(m_pointer_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_eot(m_eot),
    .shunt_v(shunt_v), .bus_v(bus_v), .power(power), .current(current),
    .sample_valid(sample_valid), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int   checks = 0, failures = 0, cyc = 0, eot_cyc = 0;
  txn_t exp_txn[$];
  smp_t exp_smp[$];

  logic [15:0] regs [8];
  logic [7:0]  ptr_sel = 8'd0;
  logic        disc = 1'b0;
  logic        mdl_prev = 1'b0, mdl_pend = 1'b0, mon_prev = 1'b0;
  int          mdl_lat = 0;
  txn_t        mdl_cur;

  const smp_t S1 = '{16'h0064, 16'h1F40, 16'h0BB8, 16'h03E8};
  const smp_t S2 = '{16'h0123, 16'h2710, 16'h0456, 16'h0789};
  const smp_t S3 = '{16'hFFF0, 16'h0001, 16'h8000, 16'h7FFF};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // i2c_master + INA219 model: eot pulses three cycles after m_start falls unless disconnected.
  initial forever begin
    @(negedge clk);
    m_eot = 1'b0;
    if (mdl_pend) begin
      if (mdl_lat == 1) begin
        mdl_pend = 1'b0;
        if (!disc) begin
          if (mdl_cur.rd) m_rdata = regs[ptr_sel[2:0]];
          else begin
            ptr_sel = mdl_cur.ptr;
            if (mdl_cur.dv) regs[mdl_cur.ptr[2:0]] = mdl_cur.data;
          end
          m_eot   = 1'b1;
          eot_cyc = cyc;
        end
      end else mdl_lat--;
    end
    if (m_start && !mdl_prev) mdl_cur = '{m_rd_wr, m_data_valid, m_pointer_addr, m_wdata};
    if (!m_start && mdl_prev) begin
      mdl_pend = 1'b1;
      mdl_lat  = 3;
    end
    mdl_prev = m_start;
  end

  // Scoreboard monitor.
  initial forever begin
    txn_t e;
    smp_t s;
    @(negedge clk);
    if (m_start && !mon_prev) begin
      if (exp_txn.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_txn actual ptr=%0h rd=%0b required=none", m_pointer_addr, m_rd_wr);
      end else begin
        e = exp_txn.pop_front();
        $display("txn  rd=%0b dv=%0b ptr=%0h data=%0h", m_rd_wr, m_data_valid, m_pointer_addr, m_wdata);
        chk("txn_addr", 32'(m_slv_addr), 32'h40);
        chk("txn_rd", 32'(m_rd_wr), 32'(e.rd));
        if (!e.rd) begin
          chk("txn_dv", 32'(m_data_valid), 32'(e.dv));
          chk("txn_ptr", 32'(m_pointer_addr), 32'(e.ptr));
          if (e.dv) chk("txn_data", 32'(m_wdata), 32'(e.data));
        end else begin
          chk("gap_cycles", 32'(cyc - eot_cyc - 1), 32'(GAPC));
        end
      end
    end
    if (sample_valid) begin
      if (exp_smp.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_sample actual shunt=%0h required=none", shunt_v);
      end else begin
        s = exp_smp.pop_front();
        chk("shunt_v", 32'(shunt_v), 32'(s.s));
        chk("bus_v", 32'(bus_v), 32'(s.b));
        chk("power", 32'(power), 32'(s.p));
        chk("current", 32'(current), 32'(s.c));
      end
    end
    mon_prev = m_start;
  end

  task automatic push_cfg();
    exp_txn.push_back('{1'b0, 1'b1, 8'h00, 16'h399F});
    exp_txn.push_back('{1'b0, 1'b1, 8'h05, 16'h1000});
  endtask

  task automatic push_read(input int i);
    exp_txn.push_back('{1'b0, 1'b0, 8'(i), 16'h0000});
    exp_txn.push_back('{1'b1, 1'b0, 8'(i), 16'h0000});
  endtask

  task automatic push_poll(input smp_t s);
    for (int i = 1; i <= 4; i++) push_read(i);
    exp_smp.push_back(s);
  endtask

  task automatic set_regs(input smp_t s);
    regs[1] = s.s; regs[2] = s.b; regs[3] = s.p; regs[4] = s.c;
  endtask

  task automatic wait_sample(input string name, output int at);
    at = -1;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (sample_valid) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=no_sample required=sample_valid", name);
    end
  endtask

  task automatic wait_start(input logic [7:0] ptr, input logic rd, output logic found);
    found = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (m_start && m_pointer_addr == ptr && m_rd_wr == rd) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("FAIL wait_start_%0h actual=none required=m_start", ptr);
    end
  endtask

  initial begin
    int   t1, t2, t3, n;
    logic found;
    for (int i = 0; i < 8; i++) regs[i] = 16'd0;
    set_regs(S1);

    repeat (3) @(negedge clk);
    chk("rst_m_start", 32'(m_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sample_valid", 32'(sample_valid), 32'd0);
    chk("rst_outputs", 32'(shunt_v | bus_v | power | current), 32'd0);
    chk("rst_cmd", 32'({m_slv_addr, m_pointer_addr} | 15'(m_wdata)), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Configure then two polls.
    push_cfg();
    push_poll(S1);
    push_poll(S2);
    enable = 1'b1;
    wait_sample("sample1", t1);
    chk("slave_reg00", 32'(regs[0]), 32'h399F);
    chk("slave_reg05", 32'(regs[5]), 32'h1000);
    set_regs(S2);
    wait_sample("sample2", t2);
    chk("sample_spacing", 32'(t2 - t1), 32'(SAMPLE_SPACING));

    // Drop enable during the bus-voltage read.
    push_read(1);
    push_read(2);
    wait_start(8'h02, 1'b1, found);
    enable = 1'b0;
    repeat (300) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_txn_queue", 32'(exp_txn.size()), 32'd0);
    chk("idle_hold_shunt", 32'(shunt_v), 32'(S2.s));

    // Re-enable restarts with configuration.
    push_cfg();
    push_poll(S3);
    set_regs(S3);
    enable = 1'b1;
    wait_sample("sample3", t3);

    // Disconnected slave: the next pointer write times out.
    disc = 1'b1;
    exp_txn.push_back('{1'b0, 1'b0, 8'h01, 16'h0000});
    wait_start(8'h01, 1'b0, found);
    n = 0;
    while (m_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!err && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_cycles", 32'(n), 32'(TMO));
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_busy", 32'(busy), 32'd0);
    disc = 1'b0;
    push_cfg();
    push_poll(S1);
    set_regs(S1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cleared", 32'(err), 32'd0);
    wait_sample("sample4", t3);

    // Reconfig request repeats configuration before the next sample.
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    push_cfg();
    push_poll(S2);
    set_regs(S2);
    wait_sample("sample5", t3);

    // Reset in the middle of the calibration write.
    reconfig = 1'b1;
    @(negedge clk);
    reconfig = 1'b0;
    push_cfg();
    wait_start(8'h05, 1'b0, found);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_m_start", 32'(m_start), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_shunt", 32'(shunt_v), 32'd0);
    chk("midrst_current", 32'(current), 32'd0);
    chk("midrst_ptr", 32'(m_pointer_addr), 32'd0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    push_cfg();
    push_poll(S1);
    set_regs(S1);
    wait_sample("sample6", t3);

    repeat (5) @(negedge clk);
    chk("end_txn_queue", 32'(exp_txn.size()), 32'd0);
    chk("end_smp_queue", 32'(exp_smp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
